// File: rtl/ml_accel_pkg.sv
// ml_accel_pkg: types and default sizes shared by the ML accelerator blocks
// (RAM wrapper, multi-core CNN array, RAM-port arbiter).
//   DEF_N / DEF_ADDR_W / DEF_DATA_W / DEF_MAX_BURST : default sizes
//   arb_state_t : arbiter ownership state (IDLE = nobody owns port b)
//   cnt_width() : width of a counter that spans max_burst beats (min 1 bit)
package ml_accel_pkg;

  localparam int DEF_N         = 4;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req   [N-1:0]  request vector
//   last  [IW-1:0] index of the previous owner; the search starts at last+1
//                  and wraps modulo N, so last itself has lowest priority
//   found          at least one request bit set
//   idx   [IW-1:0] first set request index in round-robin order
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last) + k) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/cnn_ram_arbiter.sv
// cnn_ram_arbiter: round-robin arbiter sharing RAM port b among N CNN cores.
//   clk, rst            clock, synchronous active-high reset
//   req/we [N]          per-core request and write enable
//   addr/wdata [N*W]    per-core address / write data, core i at [i*W +: W]
//   gnt [N]             registered one-hot grant
//   rvalid [N], rdata   read return strobe (one cycle after the read beat)
//   ram_we/addr/wdata   drive to RAM port b; ram_q is its read data
//   busy                a core owns the port
//   arb_state           current ownership state (debug visibility)
//
// Handshake: a core raises req[i] with we/addr/wdata and holds them stable
// until a beat is taken, i.e. a cycle where gnt[i]=1 and req[i]=1. Each such
// cycle transfers exactly one beat; the core may then present the next beat
// or drop req. Reads return on rvalid[i] the cycle after their beat.
module cnn_ram_arbiter
  import ml_accel_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        we,
  input  logic [N*ADDR_W-1:0] addr,
  input  logic [N*DATA_W-1:0] wdata,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_q,
  output logic                busy,
  output arb_state_t          arb_state
);

  localparam int IW = $clog2(N);
  localparam int CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  rvalid_q;
  logic [N-1:0]  owner_mask;
  logic          beat, expire, arbitrate;
  logic          pick_found;
  logic [IW-1:0] pick_idx;

  rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_mask = {{(N-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    beat      = (state_q == OWN) && req[owner_q];
    // Burst expiry only forces a hand-over when someone else is waiting;
    // a lone owner keeps streaming and the counter simply wraps.
    expire    = beat && (count_q == LAST_BEAT) && |(req & ~owner_mask);
    arbitrate = (state_q == IDLE) || !req[owner_q] || expire;

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;

    if (arbitrate) begin
      count_d = '0;
      if (pick_found) begin
        state_d = OWN;
        owner_d = pick_idx;
        last_d  = pick_idx;
      end else begin
        state_d = IDLE;
      end
    end else if (beat) begin
      count_d = (count_q == LAST_BEAT) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IW'(N - 1);
      count_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      count_q  <= count_d;
      rvalid_q <= (beat && !we[owner_q]) ? owner_mask : '0;
    end
  end

  assign gnt       = (state_q == OWN) ? owner_mask : '0;
  assign busy      = (state_q == OWN);
  assign rvalid    = rvalid_q;
  assign rdata     = ram_q;
  assign arb_state = state_q;
  // Write strobe is gated by rst so a beat in the reset cycle never lands.
  assign ram_we    = beat && we[owner_q] && !rst;
  assign ram_addr  = (state_q == OWN) ? addr[int'(owner_q)*ADDR_W +: ADDR_W] : '0;
  assign ram_wdata = (state_q == OWN) ? wdata[int'(owner_q)*DATA_W +: DATA_W] : '0;

endmodule
